dmem_bus_demux: RTL
===================

Name: dmem_bus_demux

Overview:
- Splits the core's single load/store request port into two downstream targets: T0 is data RAM and T1 is the MMIO peripheral block.
- Targets are selected by address decode. Only one transaction may be outstanding.
- Each target's response is returned to the core as a registered response.
- Sits between the load/store datapath and the memory/peripheral slaves. It performs the distribution that a write-back select mux performs in reverse.

Parameters:
- T0_BASE, 32'h0000_0000, RAM base address.
- T0_MASK, 32'hFFFF_C000, RAM match mask (16 KiB).
- T1_BASE, 32'h1000_0000, MMIO base address.
- T1_MASK, 32'hFFFF_F000, MMIO match mask (4 KiB).
- TIMEOUT_CYCLES, 256, watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  demux can accept a request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables.
- resp_valid  out  1  one-cycle response pulse to core.
- resp_rdata  out  32  load data.
- resp_err  out  1  unmapped address or timeout.
- tN_valid  out  1  request to target N (N = 0, 1).
- tN_ready  in  1  target N accepts.
- tN_addr  out  32  latched address.
- tN_we  out  1  latched write enable.
- tN_wdata  out  32  latched store data.
- tN_be  out  4  latched byte enables.
- tN_resp_valid  in  1  target N response.
- tN_resp_rdata  in  32  target N read data.

Behaviour:
- Reset, asynchronous:
  - state = IDLE.
  - resp_valid, resp_err, resp_rdata, tN_valid, tN_addr, tN_we, tN_wdata, tN_be all 0.
  - Any in-flight transaction is dropped with no response.
- req_ready is combinational: it is 1 exactly when state == IDLE, including immediately after reset.
- FSM IDLE:
  - On req_valid & req_ready, latch addr, we, wdata and be.
  - Decode: (addr & T0_MASK) == T0_BASE selects T0. Otherwise (addr & T1_MASK) == T1_BASE selects T1. T0 wins if both match.
  - Next state is ISSUE for a matched address, ERR if neither matches.
- FSM ISSUE:
  - Only the selected tN_valid = 1; the other target's outputs hold 0.
  - Fields are held stable until tN_ready, then go to WAIT.
  - A tN_resp_valid arriving in ISSUE is ignored.
- FSM WAIT:
  - On the selected target's tN_resp_valid: register resp_rdata = tN_resp_rdata, resp_valid = 1, resp_err = 0. Go to IDLE.
  - The non-selected target's response is ignored.
- FSM ERR: resp_valid = 1, resp_err = 1, resp_rdata = 0 for one cycle, then IDLE.
- resp_valid is a single-cycle pulse. The core must sample it; there is no resp_ready.
- Latency:
  - Mapped access: request accept edge, then ISSUE for ≥1 cycle, then target latency, then resp_valid the cycle after tN_resp_valid.
  - Unmapped access: resp_valid 1 cycle after accept.
- Stores also require a target response, with rdata ignored by the core.
- Back-to-back: a new request can be accepted in the cycle resp_valid is high (state is IDLE).
- tN_valid deasserts in the cycle after the tN_ready handshake.

Optional Feature:
- Macro: DMEM_DEMUX_TIMEOUT_EN.
- Defined:
  - A cycle counter, width $clog2(TIMEOUT_CYCLES+1), clears on entering ISSUE and counts in ISSUE and WAIT.
  - On reaching TIMEOUT_CYCLES: tN_valid drops, resp_valid = 1, resp_err = 1, resp_rdata = 0, go to IDLE.
  - A late target response is ignored.
- Undefined: no counter; the FSM waits indefinitely in ISSUE or WAIT.

Decomposition:
- Package dmem_bus_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT, ERR};
  - the target-select typedef {SEL_T0, SEL_T1, SEL_NONE};
  - the request struct (addr, we, wdata, be);
  - the constant ERR_RDATA = 32'h0.
- Sub-module dmem_addr_decode: combinational, maps addr and parameters to a target select, giving one place to add targets.

Test Plan:
- Load 0x0000_0010, T0 ready immediately, T0 responds 2 cycles later with 0xCAFE_F00D → t0_valid for 1 cycle, t1_valid never, resp_valid pulse with rdata 0xCAFE_F00D, err 0.
- Store 0x1000_0004, wdata 0x55, be 4'b0001, t1_ready held low 3 cycles → t1 fields stable while waiting, req_ready 0 throughout, response after t1_resp_valid.
- Unmapped load 0x2000_0000 → no tN_valid, resp_valid + resp_err 1 cycle after accept, rdata 0.
- Spurious t1_resp_valid during a T0 transaction → ignored; only T0's data is returned.
- rst_n asserted during WAIT → all outputs 0 asynchronously, req_ready 1 after release, no resp_valid; the next request completes normally.
- With DMEM_DEMUX_TIMEOUT_EN and TIMEOUT_CYCLES = 8, T0 never responds → resp_err pulse 8 cycles after ISSUE entry; a T0 response arriving afterwards is ignored.

Source files
------------

// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the load/store bus demultiplexer.
package dmem_bus_pkg;

   // Transaction FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ERR   = 2'd3
   } state_e;

   // Downstream target chosen by address decode
   typedef enum logic [1:0] {
      SEL_T0   = 2'd0,
      SEL_T1   = 2'd1,
      SEL_NONE = 2'd2
   } tsel_e;

   // Latched core request
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   // Read data returned with an error response
   localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/dmem_addr_decode.sv
// Address decoder: maps a byte address onto a target select.
// New targets are added here only; T0 has priority over T1 on overlap.
module dmem_addr_decode
   import dmem_bus_pkg::*;
#(
   parameter logic [31:0] T0_BASE = 32'h0000_0000,
   parameter logic [31:0] T0_MASK = 32'hFFFF_C000,
   parameter logic [31:0] T1_BASE = 32'h1000_0000,
   parameter logic [31:0] T1_MASK = 32'hFFFF_F000
) (
   input  logic [31:0] addr,
   output logic [1:0]  sel
);

   // Priority match of the address against each target window
   always_comb begin
      sel = SEL_NONE;
      if ((addr & T0_MASK) == T0_BASE) begin
         sel = SEL_T0;
      end else if ((addr & T1_MASK) == T1_BASE) begin
         sel = SEL_T1;
      end else begin
         sel = SEL_NONE;
      end
   end

endmodule

// File: rtl/dmem_bus_demux.sv
// Load/store bus demultiplexer: one core request port to RAM (T0) and
// MMIO (T1), single outstanding transaction, registered response.
// Optional watchdog: define DMEM_DEMUX_TIMEOUT_EN to abort a transaction
// that sees no handshake/response within TIMEOUT_CYCLES.
module dmem_bus_demux
   import dmem_bus_pkg::*;
#(
   parameter logic [31:0] T0_BASE        = 32'h0000_0000,
   parameter logic [31:0] T0_MASK        = 32'hFFFF_C000,
   parameter logic [31:0] T1_BASE        = 32'h1000_0000,
   parameter logic [31:0] T1_MASK        = 32'hFFFF_F000,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        t0_valid,
   input  logic        t0_ready,
   output logic [31:0] t0_addr,
   output logic        t0_we,
   output logic [31:0] t0_wdata,
   output logic [3:0]  t0_be,
   input  logic        t0_resp_valid,
   input  logic [31:0] t0_resp_rdata,
   output logic        t1_valid,
   input  logic        t1_ready,
   output logic [31:0] t1_addr,
   output logic        t1_we,
   output logic [31:0] t1_wdata,
   output logic [3:0]  t1_be,
   input  logic        t1_resp_valid,
   input  logic [31:0] t1_resp_rdata
);

   state_e      state_r;
   tsel_e       sel_r;
   logic [1:0]  dec_sel_s;
   req_t        req_s;
   req_t        t0_req_r;
   req_t        t1_req_r;
   logic        t0_valid_r;
   logic        t1_valid_r;
   logic        resp_valid_r;
   logic        resp_err_r;
   logic [31:0] resp_rdata_r;
   logic        sel_ready_s;
   logic        sel_resp_valid_s;
   logic [31:0] sel_rdata_s;
   logic        timeout_s;

   assign req_s = '{addr: req_addr, we: req_we, wdata: req_wdata, be: req_be};
   assign req_ready = (state_r == IDLE);

   dmem_addr_decode #(
      .T0_BASE (T0_BASE),
      .T0_MASK (T0_MASK),
      .T1_BASE (T1_BASE),
      .T1_MASK (T1_MASK)
   ) u_decode (
      .addr (req_addr),
      .sel  (dec_sel_s)
   );

   // Route the selected target's handshake and response back to the FSM
   always_comb begin
      sel_ready_s      = 1'b0;
      sel_resp_valid_s = 1'b0;
      sel_rdata_s      = 32'h0000_0000;
      case (sel_r)
         SEL_T0: begin
            sel_ready_s      = t0_ready;
            sel_resp_valid_s = t0_resp_valid;
            sel_rdata_s      = t0_resp_rdata;
         end
         SEL_T1: begin
            sel_ready_s      = t1_ready;
            sel_resp_valid_s = t1_resp_valid;
            sel_rdata_s      = t1_resp_rdata;
         end
         default: begin
            sel_ready_s      = 1'b0;
            sel_resp_valid_s = 1'b0;
            sel_rdata_s      = 32'h0000_0000;
         end
      endcase
   end

`ifdef DMEM_DEMUX_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wdog_cnt_r;

   // Watchdog: zeroed while idle, counts every cycle a target owes us something
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == IDLE) begin
         wdog_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ISSUE) || (state_r == WAIT)) begin
         wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
      end else begin
         wdog_cnt_r <= wdog_cnt_r;
      end
   end

   assign timeout_s = ((state_r == ISSUE) || (state_r == WAIT)) &&
                      (wdog_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   // The watchdog limit has no effect in this build
   logic unused_timeout_s;
   assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
   assign timeout_s        = 1'b0;
`endif

   // Transaction FSM with registered target requests and core response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         sel_r        <= SEL_NONE;
         t0_req_r     <= '0;
         t1_req_r     <= '0;
         t0_valid_r   <= 1'b0;
         t1_valid_r   <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
      end else begin
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  sel_r <= tsel_e'(dec_sel_s);
                  case (dec_sel_s)
                     SEL_T0: begin
                        t0_req_r   <= req_s;
                        t1_req_r   <= '0;
                        t0_valid_r <= 1'b1;
                        state_r    <= ISSUE;
                     end
                     SEL_T1: begin
                        t0_req_r   <= '0;
                        t1_req_r   <= req_s;
                        t1_valid_r <= 1'b1;
                        state_r    <= ISSUE;
                     end
                     default: begin
                        t0_req_r <= '0;
                        t1_req_r <= '0;
                        state_r  <= ERR;
                     end
                  endcase
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               if (sel_ready_s) begin
                  t0_valid_r <= 1'b0;
                  t1_valid_r <= 1'b0;
                  state_r    <= WAIT;
               end else if (timeout_s) begin
                  t0_valid_r   <= 1'b0;
                  t1_valid_r   <= 1'b0;
                  resp_valid_r <= 1'b1;
                  resp_err_r   <= 1'b1;
                  resp_rdata_r <= ERR_RDATA;
                  state_r      <= IDLE;
               end else begin
                  state_r <= ISSUE;
               end
            end
            WAIT: begin
               if (sel_resp_valid_s) begin
                  resp_valid_r <= 1'b1;
                  resp_err_r   <= 1'b0;
                  resp_rdata_r <= sel_rdata_s;
                  state_r      <= IDLE;
               end else if (timeout_s) begin
                  resp_valid_r <= 1'b1;
                  resp_err_r   <= 1'b1;
                  resp_rdata_r <= ERR_RDATA;
                  state_r      <= IDLE;
               end else begin
                  state_r <= WAIT;
               end
            end
            ERR: begin
               resp_valid_r <= 1'b1;
               resp_err_r   <= 1'b1;
               resp_rdata_r <= ERR_RDATA;
               state_r      <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign resp_valid = resp_valid_r;
   assign resp_err   = resp_err_r;
   assign resp_rdata = resp_rdata_r;
   assign t0_valid   = t0_valid_r;
   assign t0_addr    = t0_req_r.addr;
   assign t0_we      = t0_req_r.we;
   assign t0_wdata   = t0_req_r.wdata;
   assign t0_be      = t0_req_r.be;
   assign t1_valid   = t1_valid_r;
   assign t1_addr    = t1_req_r.addr;
   assign t1_we      = t1_req_r.we;
   assign t1_wdata   = t1_req_r.wdata;
   assign t1_be      = t1_req_r.be;

endmodule
